// File: rtl/cache_control_nway.sv
// N-way set-associative write-back/write-allocate cache controller with true-LRU replacement and full flush.
// Latency: hit responds 2 cycles after acceptance; a miss adds an optional write-back plus a refill handshake.
// Backpressure: req_ready only in IDLE with no flush pending; memory transactions hold until mem_ready.
module cache_control_nway #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAYS   = 2,
    parameter int SETS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESP, S_FLUSH_SCAN, S_FLUSH_WB
    } state_t;

    state_t r_state, w_next;

    // Cache arrays
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];

    // Latched request and bookkeeping
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WAY_W-1:0]  r_victim;
    logic [IDX_W-1:0]  r_fset;
    logic [WAY_W-1:0]  r_fway;
    logic [DATA_W-1:0] r_rdata;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_victim;
    logic              w_victim_wb;
    logic              w_fdirty;
    logic              w_flast;
    logic              w_lru_en;
    logic [WAY_W-1:0]  w_lru_way;
    logic              w_unused_ok;

    // Byte-offset bits never participate in a lookup.
    assign w_unused_ok = &{1'b0, r_addr[1:0]};

    assign w_idx = r_addr[2 +: IDX_W];
    assign w_tag = r_addr[ADDR_W-1 -: TAG_W];

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
        end
    end

    // Victim choice: lowest-index invalid way, otherwise the oldest way
    always_comb begin
        logic inv_found;
        inv_found = 1'b0;
        w_victim  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[w_idx][i] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[w_idx][i]) begin
                inv_found = 1'b1;
                w_victim  = WAY_W'(i);
            end
        end
        w_victim_wb = !inv_found && r_dirty[w_idx][w_victim];
    end

    assign w_fdirty  = r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway];
    assign w_flast   = (r_fset == IDX_W'(SETS - 1)) && (r_fway == WAY_W'(WAYS - 1));
    assign w_lru_en  = ((r_state == S_LOOKUP) && w_hit) || ((r_state == S_REFILL) && mem_ready);
    assign w_lru_way = (r_state == S_LOOKUP) ? w_hit_way : r_victim;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (flush_req) w_next = S_FLUSH_SCAN;
                          else if (req_valid) w_next = S_LOOKUP;
            S_LOOKUP:     if (w_hit) w_next = S_RESP;
                          else if (w_victim_wb) w_next = S_WRITEBACK;
                          else w_next = S_REFILL;
            S_WRITEBACK:  if (mem_ready) w_next = S_REFILL;
            S_REFILL:     if (mem_ready) w_next = S_RESP;
            S_RESP:       w_next = S_IDLE;
            S_FLUSH_SCAN: if (w_fdirty) w_next = S_FLUSH_WB;
                          else if (w_flast) w_next = S_IDLE;
            S_FLUSH_WB:   if (mem_ready) w_next = S_FLUSH_SCAN;
            default:      w_next = S_IDLE;
        endcase
    end

    // Output decode; memory fields come straight from stable state so they hold until mem_ready
    always_comb begin
        req_ready  = (r_state == S_IDLE) && !flush_req;
        resp_valid = (r_state == S_RESP);
        flush_done = (r_state == S_FLUSH_SCAN) && !w_fdirty && w_flast;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_idx][r_victim], w_idx, 2'b00};
                mem_wdata = r_data[w_idx][r_victim];
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            end
            S_FLUSH_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[r_fset][r_fway], r_fset, 2'b00};
                mem_wdata = r_data[r_fset][r_fway];
            end
            default: ;
        endcase
    end

    assign resp_rdata = r_rdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Datapath: request latch, array updates, LRU, flush pointer, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
            end
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_victim   <= '0;
            r_fset     <= '0;
            r_fway     <= '0;
            r_rdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fset <= '0;
                    r_fway <= '0;
                    if (!flush_req && req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
                        if (r_we) begin
                            r_data[w_idx][w_hit_way]  <= r_wdata;
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                            r_rdata                   <= r_wdata;
                        end else begin
                            r_rdata <= r_data[w_idx][w_hit_way];
                        end
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_victim <= w_victim;
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        r_tag[w_idx][r_victim]   <= w_tag;
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= r_we;
                        r_data[w_idx][r_victim]  <= r_we ? r_wdata : mem_rdata;
                        r_rdata                  <= r_we ? r_wdata : mem_rdata;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (!w_fdirty && !w_flast) begin
                        if (r_fway == WAY_W'(WAYS - 1)) begin
                            r_fway <= '0;
                            r_fset <= r_fset + IDX_W'(1);
                        end else begin
                            r_fway <= r_fway + WAY_W'(1);
                        end
                    end
                end
                S_FLUSH_WB: begin
                    // The last entry is re-scanned once it is clean, which raises flush_done.
                    if (mem_ready) begin
                        r_dirty[r_fset][r_fway] <= 1'b0;
                        if (!w_flast) begin
                            if (r_fway == WAY_W'(WAYS - 1)) begin
                                r_fway <= '0;
                                r_fset <= r_fset + IDX_W'(1);
                            end else begin
                                r_fway <= r_fway + WAY_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (w_lru_en) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (WAY_W'(i) == w_lru_way)
                        r_age[w_idx][i] <= '0;
                    else if (r_age[w_idx][i] < r_age[w_idx][w_lru_way])
                        r_age[w_idx][i] <= r_age[w_idx][i] + WAY_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement, one-word lines and a valid/ready CPU handshake. It also provides a full-cache flush command and saturating hit/miss counters. It sits between the core's load/store unit and the memory port, and is the next generation of the 2-way controller. All tag, data, valid, dirty and age arrays are held internally in registers.

Parameters:
ADDR_W, 32, address width; bits [1:0] are the byte offset and are ignored.
DATA_W, 32, word width, which is also the line width.
WAYS, 2, associativity; must be a power of two and at least 2.
SETS, 16, number of sets; must be a power of two. Index is addr[2+log2(SETS)-1:2]; tag is the remaining upper bits.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  CPU request present.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data.
req_ready  out  1  controller is IDLE and can accept a request.
resp_valid  out  1  one-cycle pulse; the request has completed.
resp_rdata  out  DATA_W  word stored at the address after the access.
flush_req  in  1  start a flush; sampled only in IDLE.
flush_done  out  1  one-cycle pulse when the flush completes.
mem_req  out  1  memory transaction active.
mem_we  out  1  1 = write-back, 0 = refill.
mem_addr  out  ADDR_W  word-aligned line address.
mem_wdata  out  DATA_W  victim data for a write-back.
mem_rdata  in  DATA_W  refill data; valid when mem_ready is high.
mem_ready  in  1  memory completes the current transaction.
hit_count  out  32  saturating count of hits.
miss_count  out  32  saturating count of misses.

Behaviour:
- Reset effects: all valid and dirty bits cleared, state = IDLE, age of way i = i.
- Reset output values: req_ready=1; resp_valid, flush_done, mem_req, mem_we = 0; counters = 0; mem_addr, mem_wdata, resp_rdata = 0.
- Reset mid-operation: any in-flight memory transaction is abandoned and mem_req is low from the next cycle.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESP, FLUSH_SCAN, FLUSH_WB.
- IDLE: if flush_req, go to FLUSH_SCAN; flush takes priority over a simultaneous req_valid, which waits with req_ready=0. Otherwise, if req_valid, latch we/addr/wdata and go to LOOKUP. The request is accepted on the edge where req_valid and req_ready are both high.
- LOOKUP, hit (valid and tag match in any way):
  - write: store data, set dirty, update LRU.
  - hit_count increments.
  - go to RESP.
- LOOKUP, miss:
  - victim = lowest-index invalid way, else the way with age WAYS-1.
  - miss_count increments.
  - go to WRITEBACK if the victim is valid and dirty, else to REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata = victim data. On the edge where mem_ready=1, go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = request line address. On mem_ready=1, install the line in the victim way:
  - tag written, valid=1, dirty=req_we.
  - data = req_wdata if write, else mem_rdata.
  - update LRU, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Hit latency: acceptance edge, then LOOKUP cycle, then RESP cycle; resp_valid is high 2 cycles after acceptance.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready is sampled high.
  - mem_ready is ignored when mem_req=0.
  - mem_ready may already be high in the first cycle of mem_req, giving a zero-wait transfer.
- LRU update:
  - the accessed way gets age 0;
  - ways whose age is below the accessed way's old age increment;
  - ages in a set always remain a permutation of 0..WAYS-1.
- FLUSH_SCAN: walk entries set-major, way-minor, one entry per cycle.
  - A valid and dirty entry goes to FLUSH_WB, which performs a write-back exactly as in WRITEBACK, clears dirty (valid is kept), then resumes the scan at the next entry.
  - After the last entry, flush_done=1 for one cycle, then IDLE.
  - Flush does not change LRU or the counters.
- Counters stop at 32'hFFFFFFFF and do not wrap.

Test Plan:
1. Reset; read 0x00000000; memory responds after 3 wait cycles with 0xDEADBEEF → one refill mem_req at 0x00000000 with mem_we=0; resp_rdata=0xDEADBEEF; miss_count=1.
2. Write 0x00000000 with 0x12345678 → no mem_req; resp_valid 2 cycles after acceptance; hit_count=1; a following read returns 0x12345678.
3. Read 0x00000040 (refill 0xCAFEF00D, goes to way1), then read 0x00000080 → way0 is evicted as LRU and dirty: write-back at 0x00000000 with data 0x12345678, then refill at 0x00000080; miss_count=3.
4. Write 0x00000044, then pulse flush_req → exactly one write-back at 0x00000044. flush_done pulses after the scan. A second flush issues no mem_req and flush_done pulses 32 cycles after acceptance (SETS*WAYS=32).
5. Assert rst while the controller is in REFILL waiting on mem_ready → next cycle mem_req=0, req_ready=1, counters=0; a read of 0x00000080 then misses.
6. req_valid and flush_req both high in IDLE → the flush runs first with req_ready=0 throughout; the request is accepted in the cycle after flush_done.
